// File: rtl/calc_disp_pkg.sv
// rtl/calc_disp_pkg.sv - shared scan-state type and active-low seven-segment glyphs
package calc_disp_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        SCAN  = 1'b1
    } scan_state_t;

    // Segment order {g,f,e,d,c,b,a}, 0 = lit
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - BCD digit to active-low seven-segment decoder with blank override
module bcd_to_seg
    import calc_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed display scanner with guard time and frame-aligned loads
module seg_scan_ctrl
    import calc_disp_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int GUARD_CYC = 4
) (
    input  logic        clck,
    input  logic        reste,
    input  logic        load_req,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    input  logic        blank_lz,
    output logic        load_ack,
    output logic        frame_start,
    output logic [1:0]  digit_idx,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PCNT_MAX   = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD_CYC - 1);

    logic [PW-1:0] r_pcnt;
    logic [PW-1:0] r_gcnt;
    logic [1:0]    r_idx;
    scan_state_t   r_state;
    logic [15:0]   r_disp;
    logic [3:0]    r_dp_mask;
    logic          r_load_ack;
    logic          r_frame_start;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_tick;
    logic          w_boundary;
    logic [3:0]    w_digit;
    logic          w_upper_zero;
    logic          w_lz_blank;
    logic [6:0]    w_seg_dec;

    assign w_tick     = (r_pcnt == PCNT_MAX);
    assign w_boundary = w_tick && (r_idx == 2'd3);
    assign w_digit    = r_disp[{r_idx, 2'b00} +: 4];

    // A digit is a leading zero only if it and every digit to its left are zero
    always_comb begin
        w_upper_zero = 1'b0;
        case (r_idx)
            2'd3:    w_upper_zero = (r_disp[15:12] == 4'd0);
            2'd2:    w_upper_zero = (r_disp[15:8]  == 8'd0);
            2'd1:    w_upper_zero = (r_disp[15:4]  == 12'd0);
            default: w_upper_zero = 1'b0;
        endcase
    end

    assign w_lz_blank = blank_lz && w_upper_zero;

    bcd_to_seg u_bcd_to_seg (
        .i_bcd   (w_digit),
        .i_blank (w_lz_blank),
        .o_seg   (w_seg_dec)
    );

    always_ff @(posedge clck or negedge reste) begin
        if (!reste) begin
            r_pcnt        <= '0;
            r_gcnt        <= '0;
            r_idx         <= 2'd0;
            r_state       <= GUARD;
            r_disp        <= 16'h0000;
            r_dp_mask     <= 4'h0;
            r_load_ack    <= 1'b0;
            r_frame_start <= 1'b0;
            r_an          <= 4'hF;
            r_seg         <= SEG_BLANK;
            r_dp          <= 1'b1;
        end else begin
            r_pcnt        <= w_tick ? '0 : r_pcnt + 1'b1;
            r_an          <= (r_state == SCAN) ? ~(4'b0001 << r_idx) : 4'hF;
            r_seg         <= (r_state == SCAN) ? w_seg_dec : SEG_BLANK;
            r_dp          <= (r_state == SCAN) ? ~r_dp_mask[r_idx] : 1'b1;
            r_frame_start <= w_boundary;
            r_load_ack    <= w_boundary && load_req;

            // New data only at the 3->0 wrap so a frame never mixes old and new digits
            if (w_boundary && load_req) begin
                r_disp    <= load_data;
                r_dp_mask <= load_dp;
            end

            if (w_tick) begin
                r_idx   <= r_idx + 2'd1;
                r_gcnt  <= '0;
                r_state <= GUARD;
            end else if (r_state == GUARD) begin
                r_gcnt <= r_gcnt + 1'b1;
                if (r_gcnt == GUARD_LAST) begin
                    r_state <= SCAN;
                end
            end
        end
    end

    assign load_ack    = r_load_ack;
    assign frame_start = r_frame_start;
    assign digit_idx   = r_idx;
    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the calculator's 4-digit common-anode seven-segment display. It divides the system clock into a per-digit scan tick and steps a 2-bit digit index through 0..3. It also inserts a dead-time guard between digits and drives the active-low anode, segment and decimal-point lines. A 16-bit BCD result from the calculator core is latched through a req/ack handshake only at frame boundaries, so the display never tears.

## Interface
- TICK_DIV, 50000: clock cycles per digit slot; legal range 4..2^20.
- GUARD_CYC, 4: all-anodes-off cycles at the start of each slot; legal range 1..TICK_DIV-2.
- clck  in  1  system clock, rising edge.
- reste  in  1  reset, asynchronous, active-low.
- load_req  in  1  request to display load_data/load_dp; hold high with stable data until load_ack.
- load_data  in  16  four BCD digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- load_dp  in  4  decimal-point mask, bit n = digit n, 1 = lit.
- blank_lz  in  1  leading-zero blanking enable, sampled live.
- load_ack  out  1  one-cycle pulse: data latched.
- frame_start  out  1  one-cycle pulse when index wraps 3->0.
- digit_idx  out  2  current scan index.
- an  out  4  anodes, active-low, one-hot-low or all high.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Prescaler pcnt counts 0..TICK_DIV-1 and wraps; tick = (pcnt == TICK_DIV-1).
- FSM states: GUARD and SCAN.
  - On tick, from either state: idx <= idx+1 (3 wraps to 0), gcnt <= 0, state <= GUARD.
  - In GUARD without a tick: gcnt increments; when gcnt == GUARD_CYC-1, state <= SCAN.
  - SCAN holds until the next tick.
- Frame boundary = tick with idx == 3.
  - frame_start <= 1 for one cycle.
  - If load_req == 1 in that same cycle: disp_reg <= load_data, dp_reg <= load_dp, load_ack <= 1 for one cycle.
- Loads are never accepted at any other time.
- The requester drops load_req the cycle after seeing load_ack. If load_req is still high at the next boundary, a second load is taken; this is legal.
- A load_req that rises in the same cycle as a boundary tick is accepted on that tick.
- Digit value d = disp_reg[4*idx +: 4].
  - d in 0..9: standard glyph.
  - d in A..F: dash (g only, seg = 7'h3F).
- Leading-zero blanking, when blank_lz = 1:
  - Digit n (n = 3..1) is blanked (seg = 7'h7F) if it and every higher digit are 0.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
- dp = ~dp_reg[idx] in SCAN; 1 in GUARD.
- Reset (reste low, any time, asynchronous):
  - pcnt = 0, gcnt = 0, idx = 0, state = GUARD.
  - disp_reg = 0, dp_reg = 0.
  - an = 4'hF, seg = 7'h7F, dp = 1, load_ack = 0, frame_start = 0, digit_idx = 0.
  - A pending request is dropped without ack; the requester re-asserts it after reset.

## Timing
- an, seg and dp are registered. They reflect the state and idx of the previous cycle: an <= (state == SCAN) ? ~(4'b1 << idx) : 4'hF.
- Per slot, the anode is low for TICK_DIV-GUARD_CYC cycles and high for GUARD_CYC cycles.
- digit_idx changes on the tick edge. an goes to all high on the following edge.
- load_ack and frame_start are asserted on the edge after the boundary-tick cycle. They coincide, and each lasts one cycle.
- The new value first appears on digit 0 of the frame that begins at that boundary.
- Load latency is 1 to 4*TICK_DIV cycles from load_req rising.

## Structure
- Shared package calc_disp_pkg holds:
  - state typedef {GUARD, SCAN};
  - constants SEG_BLANK = 7'h7F and SEG_DASH = 7'h3F;
  - the 0..9 glyph constants.
- One sub-module, bcd_to_seg: combinational 4-bit to 7-bit active-low decoder with a blank input, instantiated once on the muxed digit.
- Prescaler, FSM, index register, handshake and blanking logic stay in seg_scan_ctrl.

## Test plan
All scenarios use TICK_DIV = 8 and GUARD_CYC = 2.
- **Reset:** reste low → an = F, seg = 7F, dp = 1, load_ack = 0. After release: an = 4'hF for 3 edges, then an = 1110 for 6 cycles, then F for 2 cycles, then 1101.
- **Handshake:** load_req with 16'h1234 and load_dp = 0100 raised mid-frame → load_ack exactly once, 1 cycle after the idx 3→0 tick. The next frame shows 4,3,2,1 on an 1110, 1101, 1011, 0111; dp is low only while an = 1011.
- **Blanking:** 16'h0007 with blank_lz = 1 → digits 3..1 seg = 7F, digit 0 seg = 7'h78. With blank_lz = 0 → digits 3..1 seg = 7'h40. 16'h0000 with blank_lz = 1 → digit 0 seg = 7'h40.
- **Invalid BCD:** 16'hA0F1 → digits 3 and 1 seg = 7'h3F, digit 2 = 7'h40, digit 0 = 7'h79.
- **Reset mid-request:** load_req high, reste pulsed low before the boundary → no load_ack, disp_reg stays 0, and all outputs return to reset values immediately.
- **Wrap:** free run for 3 frames → frame_start every 32 cycles; digit_idx sequence 0,1,2,3,0; load_req held high across 2 boundaries gives 2 acks 32 cycles apart.
